pmem_arbiter: RTL and testbench

- Shares the single physical-memory port (cacheline adapter side) between two line-granular requesters.
- Requester I is the instruction cache; it is read-only.
- Requester D is the data side (the eviction buffer output); it issues reads and writebacks.
- Sits between the cache hierarchy and the cacheline adapter.
- Grants exactly one requester per memory transaction. Arbitration is round-robin, and a grant is held until the memory response arrives.

---
 rtl/pmem_arbiter_pkg.sv | 37 +++
 rtl/pmem_arbiter.sv | 107 ++++++++++
 tb/tb_pmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, grant identity
// and the round-robin winner selection used in IDLE.
package pmem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Winner for the next transaction; on contention the side that did not
  // win last time is chosen.
  function automatic arb_state_e rr_select(input logic   req_i,
                                           input logic   req_d,
                                           input grant_t last_grant);
    arb_state_e nxt;
    nxt = IDLE;
    if (req_i && req_d) begin
      if (last_grant == GRANT_I) nxt = SERVE_D;
      else                       nxt = SERVE_I;
    end else if (req_i) begin
      nxt = SERVE_I;
    end else if (req_d) begin
      nxt = SERVE_D;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing the cacheline-adapter memory port between the
// read-only instruction cache (I) and the data-side eviction buffer (D).
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       req_i;
  logic       req_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Address and write data are never latched: requesters hold them stable
  // until their resp, so the granted side is muxed straight through.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_address  = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;

    unique case (state_q)
      IDLE: begin
        // mem_resp here is stray and deliberately dropped.
        state_d = rr_select(req_i, req_d, last_grant_q);
        if (state_d == SERVE_I) begin
          last_grant_d = GRANT_I;
        end else if (state_d == SERVE_D) begin
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I: begin
        mem_address = i_address;
        mem_read    = 1'b1;
        i_resp      = mem_resp;
        i_rdata     = mem_rdata;
        if (mem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        mem_address = d_address;
        // An illegal read+write collapses to a write so the memory port never
        // sees both strobes.
        mem_write   = d_write;
        mem_read    = d_read & ~d_write;
        mem_wdata   = d_wdata;
        d_resp      = mem_resp;
        d_rdata     = mem_rdata;
        if (mem_resp) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  a_d_cmd_onehot: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write))
    else $error("pmem_arbiter: d_read and d_write asserted together");

  a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(i_resp && d_resp))
    else $error("pmem_arbiter: i_resp and d_resp in the same cycle");

  a_mem_cmd_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write))
    else $error("pmem_arbiter: mem_read and mem_write in the same cycle");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a transaction-level ownership model checked
// every cycle, plus literal expectations on grant order, latency and data.
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [LINE_W-1:0] GARBAGE = {8{32'hDEAD_BEEF}};

  typedef struct {
    bit              wr;
    logic [31:0]     addr;
    logic [LINE_W-1:0] data;
  } dreq_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rdata_for(input logic [31:0] addr);
    if (addr == 32'h0000_1000) return {32{8'hAA}};
    return {8{addr ^ 32'hC3C3_0000}};
  endfunction

  // ---------------- model + monitor ----------------
  int          owner = 0;       // 0 none, 1 I, 2 D
  int          grants[$];
  bit          model_on = 0;
  int          cyc = 0;
  bit          prev_strobe = 0;
  logic [31:0] addr_log[$];
  int          rise_log[$];
  int          i_resp_cnt = 0, d_resp_cnt = 0;
  int          i_resp_cyc = 0, d_resp_cyc = 0;
  logic [LINE_W-1:0] i_rdata_last, d_rdata_last, wdata_last;

  logic [31:0]       e_addr;
  logic              e_read, e_write, e_iresp, e_dresp, chk_wd;
  logic [LINE_W-1:0] e_wdata, e_irdata, e_drdata;
  int                lastg;

  initial begin : cmp
    forever begin
      @(negedge clk);
      cyc++;
      if (model_on) begin
        e_addr = '0; e_read = 0; e_write = 0; e_wdata = '0;
        e_iresp = 0; e_dresp = 0; e_irdata = '0; e_drdata = '0; chk_wd = 1;
        if (owner == 1) begin
          e_addr = i_address; e_read = 1; e_iresp = mem_resp; e_irdata = mem_rdata;
          chk_wd = 0;
        end else if (owner == 2) begin
          e_addr = d_address; e_write = d_write; e_read = d_read && !d_write;
          e_wdata = d_wdata; e_dresp = mem_resp; e_drdata = mem_rdata;
        end
        chk32("mem_address", mem_address, e_addr);
        chk32("mem_read", 32'(mem_read), 32'(e_read));
        chk32("mem_write", 32'(mem_write), 32'(e_write));
        if (chk_wd) chk_line("mem_wdata", mem_wdata, e_wdata);
        chk32("i_resp", 32'(i_resp), 32'(e_iresp));
        chk32("d_resp", 32'(d_resp), 32'(e_dresp));
        chk_line("i_rdata", i_rdata, e_irdata);
        chk_line("d_rdata", d_rdata, e_drdata);
      end
      if ((mem_read || mem_write) && !prev_strobe) begin
        addr_log.push_back(mem_address);
        rise_log.push_back(cyc);
      end
      prev_strobe = mem_read || mem_write;
      if (i_resp) begin i_resp_cnt++; i_resp_cyc = cyc; i_rdata_last = i_rdata; end
      if (d_resp) begin d_resp_cnt++; d_resp_cyc = cyc; d_rdata_last = d_rdata; end
      if (mem_write) wdata_last = mem_wdata;
      // next owner across the coming edge
      if (rst) begin
        owner = 0;
        grants.delete();
        model_on = 1;
      end else if (owner == 0) begin
        lastg = (grants.size() != 0) ? grants[grants.size()-1] : 1;
        if (i_read && (d_read || d_write)) owner = (lastg == 1) ? 2 : 1;
        else if (i_read) owner = 1;
        else if (d_read || d_write) owner = 2;
        if (owner != 0) grants.push_back(owner);
      end else if (mem_resp) begin
        owner = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] iq[$];
  dreq_t       dq[$];
  int          lat = 3;
  bit          resp_en = 1;
  int          rcnt = 0;
  bit          i_seen, d_seen;

  function automatic logic [31:0] log_at(input int idx);
    if (idx < addr_log.size()) return addr_log[idx];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int rise_at(input int idx);
    if (idx < rise_log.size()) return rise_log[idx];
    return -1000;
  endfunction

  task automatic tick();
    @(negedge clk);
    i_seen = i_resp;
    d_seen = d_resp;
    @(posedge clk);
    #1;
    if (resp_en) begin
      mem_resp  = 1'b0;
      mem_rdata = GARBAGE;
      if (mem_read || mem_write) begin
        rcnt++;
        if (rcnt == lat) begin
          mem_resp  = 1'b1;
          mem_rdata = rdata_for(mem_address);
          rcnt      = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
    #1;
    if (i_seen && i_read) begin i_read = 1'b0; void'(iq.pop_front()); end
    if (!i_read && iq.size() != 0) begin i_read = 1'b1; i_address = iq[0]; end
    if (d_seen && (d_read || d_write)) begin
      d_read = 1'b0; d_write = 1'b0; void'(dq.pop_front());
    end
    if (!(d_read || d_write) && dq.size() != 0) begin
      d_read = !dq[0].wr; d_write = dq[0].wr; d_address = dq[0].addr; d_wdata = dq[0].data;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iq.delete(); dq.delete();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    resp_en = 1; rcnt = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk32("rst_mem_read", 32'(mem_read), 32'd0);
    chk32("rst_mem_write", 32'(mem_write), 32'd0);
    chk32("rst_mem_address", mem_address, 32'd0);
    chk32("rst_resps", 32'({i_resp, d_resp}), 32'd0);
  endtask

  task automatic run_until_idle(input string name, input int max);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || i_read || d_read || d_write) && n < max) begin
      tick();
      n++;
    end
    chk32({name, "_completed"}, 32'(n < max), 32'd1);
    tick();
  endtask

  int base, ib, db, req_seen;
  logic [31:0] exp_fair[6];
  logic [31:0] exp_evict[3];

  initial begin : main
    rst = 1'b1; i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = GARBAGE;

    // I-only read, 5-cycle memory latency
    do_reset();
    lat = 5; base = addr_log.size(); ib = i_resp_cnt; db = d_resp_cnt;
    iq.push_back(32'h0000_1000);
    tick();
    req_seen = cyc + 1;
    run_until_idle("ionly", 40);
    chk32("ionly_addr", log_at(base), 32'h0000_1000);
    chk32("ionly_grant_latency", 32'(rise_at(base) - req_seen), 32'd1);
    chk32("ionly_resp_cycle", 32'(i_resp_cyc - rise_at(base)), 32'd4);
    chk_line("ionly_rdata", i_rdata_last, {32{8'hAA}});
    chk32("ionly_iresp_cnt", 32'(i_resp_cnt - ib), 32'd1);
    chk32("ionly_dresp_cnt", 32'(d_resp_cnt - db), 32'd0);

    // D writeback
    lat = 3; base = addr_log.size(); ib = i_resp_cnt; db = d_resp_cnt;
    dq.push_back('{wr: 1'b1, addr: 32'h0000_2040, data: {32{8'h55}}});
    run_until_idle("dwb", 40);
    chk32("dwb_addr", log_at(base), 32'h0000_2040);
    chk_line("dwb_wdata", wdata_last, {32{8'h55}});
    chk32("dwb_dresp_cnt", 32'(d_resp_cnt - db), 32'd1);
    chk32("dwb_iresp_cnt", 32'(i_resp_cnt - ib), 32'd0);

    // contention right after reset: D first, I after one idle cycle
    do_reset();
    lat = 2; base = addr_log.size();
    iq.push_back(32'h0000_1100);
    dq.push_back('{wr: 1'b0, addr: 32'h0000_2200, data: '0});
    run_until_idle("contend", 40);
    chk32("contend_first", log_at(base), 32'h0000_2200);
    chk32("contend_second", log_at(base + 1), 32'h0000_1100);
    chk32("contend_idle_gap", 32'(rise_at(base + 1) - d_resp_cyc), 32'd2);
    chk_line("contend_d_rdata", d_rdata_last, rdata_for(32'h0000_2200));
    chk_line("contend_i_rdata", i_rdata_last, rdata_for(32'h0000_1100));

    // fairness: six back-to-back contended transactions
    do_reset();
    lat = 2; base = addr_log.size();
    exp_fair = '{32'hB000, 32'hA000, 32'hB040, 32'hA040, 32'hB080, 32'hA080};
    for (int k = 0; k < 3; k++) begin
      iq.push_back(32'hA000 + 32'(k * 64));
      dq.push_back('{wr: 1'b0, addr: 32'hB000 + 32'(k * 64), data: '0});
    end
    run_until_idle("fair", 80);
    for (int k = 0; k < 6; k++) chk32($sformatf("fair_order%0d", k), log_at(base + k), exp_fair[k]);

    // eviction: D read, I read, D writeback
    do_reset();
    lat = 3; base = addr_log.size();
    exp_evict = '{32'h3000, 32'h5000, 32'h4000};
    dq.push_back('{wr: 1'b0, addr: 32'h3000, data: '0});
    dq.push_back('{wr: 1'b1, addr: 32'h4000, data: {32{8'h77}}});
    iq.push_back(32'h5000);
    run_until_idle("evict", 60);
    for (int k = 0; k < 3; k++) chk32($sformatf("evict_order%0d", k), log_at(base + k), exp_evict[k]);
    chk_line("evict_wdata", wdata_last, {32{8'h77}});

    // reset during SERVE_I aborts without a resp
    do_reset();
    lat = 10; ib = i_resp_cnt;
    iq.push_back(32'h6000);
    tick(); tick(); tick();
    #1;
    chk32("abort_serving", 32'(mem_read), 32'd1);
    rst = 1'b1; iq.delete(); i_read = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    chk32("abort_mem_read", 32'(mem_read), 32'd0);
    chk32("abort_mem_address", mem_address, 32'd0);
    chk32("abort_no_iresp", 32'(i_resp_cnt - ib), 32'd0);
    lat = 3; base = addr_log.size();
    iq.push_back(32'h7000);
    run_until_idle("after_abort", 40);
    chk32("after_abort_addr", log_at(base), 32'h7000);
    chk32("after_abort_iresp", 32'(i_resp_cnt - ib), 32'd1);

    // stray mem_resp while idle is ignored
    do_reset();
    resp_en = 0; ib = i_resp_cnt; db = d_resp_cnt;
    tick();
    mem_resp = 1'b1; mem_rdata = {8{32'h1234_5678}};
    tick();
    mem_resp = 1'b0; mem_rdata = GARBAGE;
    tick();
    chk32("stray_iresp", 32'(i_resp_cnt - ib), 32'd0);
    chk32("stray_dresp", 32'(d_resp_cnt - db), 32'd0);
    resp_en = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
